uart_reg_cmd_sched: RTL and testbench
=====================================

// Module: uart_reg_cmd_sched
// PURPOSE
//  Sequences UART register commands for the IFC test CPLD. Collects a 3-byte command frame from
//  the UART receiver byte stream and issues one transaction on the IFC register req/ack bus.
//  Returns a 2-byte response through the UART transmitter. Owns the only path from UART to IFC regs.
// PARAMETERS
//  ADDR_W        8     register address width (frame byte 1; upper bits zero-extended)
//  DATA_W        8     register data width (frame byte 2 / response byte 1)
//  BYTE_TIMEOUT  50000 sys_clk cycles allowed between frame bytes before the frame is aborted
//  ACK_TIMEOUT   255   sys_clk cycles allowed for reg_ack after reg_req rises
// PORTS
//  sys_clk        in   1       system clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  rx_valid       in   1       one-cycle strobe, rx_byte valid
//  rx_byte        in   8       received UART byte
//  tx_busy        in   1       UART transmitter busy
//  tx_start       out  1       one-cycle strobe, send tx_byte
//  tx_byte        out  8       byte to transmit, stable while tx_start=1
//  reg_req        out  1       register access request
//  reg_we         out  1       1=write, 0=read; valid while reg_req=1
//  reg_addr       out  ADDR_W  register address; valid while reg_req=1
//  reg_wdata      out  DATA_W  write data; valid while reg_req=1
//  reg_ack        in   1       one-cycle completion from register block
//  reg_rdata      in   DATA_W  read data, valid in the reg_ack cycle
//  busy           out  1       high in every state except IDLE
//  err_cnt        out  8       saturating count of dropped bytes, aborted frames and ack timeouts
// BEHAVIOUR
//  - Reset: all outputs 0 and state=IDLE on the first edge with rst=1, including mid-transaction.
//    reg_req drops without waiting for ack. err_cnt is cleared.
//  - Frame format: byte0 opcode 'W'(0x57) or 'R'(0x52), byte1 addr, byte2 data.
//    byte2 is always sent; it is ignored for reads.
//  - FSM: IDLE -> RX_ADDR -> RX_DATA -> REG_REQ -> TX_STAT -> TX_STAT_WAIT -> TX_DATA -> TX_DATA_WAIT -> IDLE.
//  - IDLE: rx_valid with a valid opcode latches we and moves to RX_ADDR.
//    Any other byte is dropped, err_cnt+1, and the FSM stays in IDLE.
//  - RX_ADDR / RX_DATA: advance on rx_valid.
//    The inter-byte counter clears on entry and on every byte. At BYTE_TIMEOUT the FSM goes to IDLE and err_cnt+1.
//  - REG_REQ: reg_req rises on the edge after the byte2 strobe (1-cycle latency).
//    reg_req, reg_we, reg_addr and reg_wdata hold stable until reg_ack is sampled 1.
//    reg_req falls on the edge that samples ack, and the FSM enters TX_STAT in that same edge.
//    No ack within ACK_TIMEOUT cycles: reg_req falls, status=error, err_cnt+1.
//  - Response byte0 (status): 'K'(0x4B) ok, 'E'(0x45) ack timeout.
//    Response byte1: reg_rdata (read ok), wdata echo (write ok), 0x00 (error).
//    reg_rdata is captured in the ack cycle.
//  - TX_STAT / TX_DATA: pulse tx_start for 1 cycle at the first cycle with tx_busy=0.
//  - TX_*_WAIT: ignore tx_busy in the cycle after the pulse, then wait for tx_busy=0.
//  - rx_valid in any state other than IDLE / RX_ADDR / RX_DATA: byte dropped, err_cnt+1.
//  - err_cnt saturates at 0xFF. Simultaneous error sources in one cycle count as +1.
//  - reg_ack outside REG_REQ is ignored.
// TESTING
//  - Write: bytes 57,10,A5 -> reg_req=1 with we=1, addr=0x10, wdata=0xA5 one cycle after the third byte.
//    Ack after 3 cycles -> tx 4B then A5.
//  - Read: bytes 52,22,00 with reg_rdata=0x3C at ack -> reg_we=0, addr=0x22; tx 4B then 3C; busy=0 at end.
//  - No ack for ACK_TIMEOUT cycles -> reg_req falls, tx 45 then 00, err_cnt=1.
//  - Bad opcode 0x41, then 57 only, then a BYTE_TIMEOUT-cycle gap -> no reg_req, err_cnt=2, FSM back in IDLE.
//  - tx_busy held high for 20 cycles around each response byte -> exactly 2 tx_start pulses, each taken only when tx_busy=0.
//    A byte received during TX is dropped with err_cnt+1.
//  - rst=1 while in REG_REQ -> reg_req=0, busy=0 next edge; a new frame after reset completes normally.

Source files
------------

// File: rtl/uart_reg_cmd_sched.sv
// UART command frame (op, addr, data) -> one IFC register req/ack transaction -> 2-byte UART response.
// reg_req rises 1 cycle after the data byte; tx_start waits for tx_busy=0; bytes arriving while busy are dropped.
`timescale 1ns/1ps
module uart_reg_cmd_sched #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int BYTE_TIMEOUT = 50000,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int AT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, REG_REQ, TX_STAT, TX_STAT_WAIT, TX_DATA, TX_DATA_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [BT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [AT_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic              reg_req_q, reg_req_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [7:0]        status_q, status_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              skip_q, skip_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_inc;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    reg_req_d   = reg_req_q;
    reg_we_d    = reg_we_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    status_d    = status_q;
    resp_d      = resp_q;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    skip_d      = skip_q;
    err_inc     = 1'b0;

    if (rx_valid && !(state_q inside {IDLE, RX_ADDR, RX_DATA}))
      err_inc = 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_byte == 8'h57 || rx_byte == 8'h52) begin
            reg_we_d   = (rx_byte == 8'h57);
            byte_cnt_d = '0;
            state_d    = RX_ADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      RX_ADDR: begin
        if (rx_valid) begin
          reg_addr_d = ADDR_W'(rx_byte);
          byte_cnt_d = '0;
          state_d    = RX_DATA;
        end else if (byte_cnt_q == BT_W'(BYTE_TIMEOUT - 1)) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_valid) begin
          reg_wdata_d = DATA_W'(rx_byte);
          reg_req_d   = 1'b1;
          ack_cnt_d   = '0;
          state_d     = REG_REQ;
        end else if (byte_cnt_q == BT_W'(BYTE_TIMEOUT - 1)) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BT_W'(1);
        end
      end
      REG_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (reg_ack) begin
          reg_req_d = 1'b0;
          status_d  = 8'h4B;
          resp_d    = reg_we_q ? reg_wdata_q : reg_rdata;
          state_d   = TX_STAT;
        end else if (ack_cnt_q == AT_W'(ACK_TIMEOUT - 1)) begin
          reg_req_d = 1'b0;
          status_d  = 8'h45;
          resp_d    = '0;
          err_inc   = 1'b1;
          state_d   = TX_STAT;
        end else begin
          ack_cnt_d = ack_cnt_q + AT_W'(1);
        end
      end
      TX_STAT: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = status_q;
          skip_d     = 1'b1;
          state_d    = TX_STAT_WAIT;
        end
      end
      TX_DATA: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = 8'(resp_q);
          skip_d     = 1'b1;
          state_d    = TX_DATA_WAIT;
        end
      end
      TX_STAT_WAIT, TX_DATA_WAIT: begin
        // tx_busy is stale during the pulse and the cycle after it.
        if (tx_start_q) begin
          skip_d = 1'b1;
        end else if (skip_q) begin
          skip_d = 1'b0;
        end else if (!tx_busy) begin
          state_d = (state_q == TX_STAT_WAIT) ? TX_DATA : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      status_q    <= '0;
      resp_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= '0;
      skip_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      reg_req_q   <= reg_req_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      status_q    <= status_d;
      resp_q      <= resp_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
      skip_q      <= skip_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;
  assign reg_req   = reg_req_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_reg_cmd_sched.sv
// Bench for uart_reg_cmd_sched: frame vector table, register responder, UART tx model, tx-byte scoreboard.
`timescale 1ns/1ps
module tb_uart_reg_cmd_sched;
  localparam int BT    = 64;
  localparam int AT    = 20;
  localparam int TXLEN = 5;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       reg_req, reg_we;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_ack = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 sys_clk = ~sys_clk;

  uart_reg_cmd_sched #(.ADDR_W(8), .DATA_W(8), .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [7:0] op, addr, data;
    int         dly;
    logic [7:0] rdata, st, dat;
    bit         err;
  } vec_t;

  int         n_vec = 0, n_bad = 0;
  logic [7:0] sb[$];
  int         ack_delay = -1;
  logic [7:0] rdata_val = 8'h00;
  logic       exp_we = 1'b0;
  logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00;
  int         req_len = 0, req_rises = 0, tx_pulses = 0;
  bit         force_busy = 1'b0;
  logic [7:0] exp_err = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge sys_clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: busy still high after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic setup_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                             input int dly, input logic [7:0] rdata);
    exp_we    = (op == 8'h57);
    exp_addr  = addr;
    exp_wdata = data;
    ack_delay = dly;
    rdata_val = rdata;
    req_len   = 0;
  endtask

  // Register block model: checks request fields, acks after ack_delay cycles (never if negative).
  initial begin
    int  req_cyc = 0;
    bit  acked = 1'b0;
    forever begin
      @(negedge sys_clk);
      reg_ack   = 1'b0;
      reg_rdata = 8'hEE;
      if (reg_req) begin
        req_len++;
        if (req_cyc == 0) req_rises++;
        check("req_we", reg_we, exp_we);
        check("req_addr", reg_addr, exp_addr);
        if (exp_we) check("req_wdata", reg_wdata, exp_wdata);
        if (!acked && ack_delay >= 0 && req_cyc == ack_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = rdata_val;
          acked     = 1'b1;
        end
        req_cyc++;
      end else begin
        req_cyc = 0;
        acked   = 1'b0;
      end
    end
  end

  // UART transmitter model plus tx scoreboard.
  initial begin
    int   busy_left = 0;
    logic prev_start = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start) begin
        tx_pulses++;
        check("tx_start_when_busy", tx_busy, 1'b0);
        check("tx_start_width", prev_start, 1'b0);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tx_unexpected: actual byte=%0h expected none", tx_byte);
        end else begin
          check("tx_byte", tx_byte, sb.pop_front());
        end
        busy_left = TXLEN;
      end
      prev_start = tx_start;
      tx_busy    = force_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   p0, r0;
    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3,      8'h00, 8'h4B, 8'hA5, 1'b0};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 0,      8'h3C, 8'h4B, 8'h3C, 1'b0};
    vecs[2] = '{8'h57, 8'h7F, 8'h81, AT - 1, 8'h00, 8'h4B, 8'h81, 1'b0};
    vecs[3] = '{8'h52, 8'h33, 8'h00, -1,     8'h00, 8'h45, 8'h00, 1'b1};
    vecs[4] = '{8'h52, 8'hFF, 8'h12, 5,      8'hFF, 8'h4B, 8'hFF, 1'b0};
    vecs[5] = '{8'h57, 8'h00, 8'h5A, 1,      8'h00, 8'h4B, 8'h5A, 1'b0};

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_reg_req", reg_req, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_tx_byte", tx_byte, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      setup_frame(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].dly, vecs[i].rdata);
      send_byte(vecs[i].op);
      send_byte(vecs[i].addr);
      check("req_before_data", reg_req, 1'b0);
      sb.push_back(vecs[i].st);
      sb.push_back(vecs[i].dat);
      send_byte(vecs[i].data);
      check("req_latency", reg_req, 1'b1);
      if (vecs[i].err) exp_err++;
      wait_idle("vec_idle", 200);
      check("vec_err_cnt", err_cnt, exp_err);
      check("vec_sb_empty", sb.size(), 0);
      if (vecs[i].dly < 0) check("ack_timeout_len", req_len, AT);
    end

    // Bad opcode, then an abandoned frame that must time out exactly at BT cycles.
    r0 = req_rises;
    send_byte(8'h41);
    exp_err++;
    check("bad_op_err", err_cnt, exp_err);
    check("bad_op_idle", busy, 1'b0);
    send_byte(8'h57);
    check("op_busy", busy, 1'b1);
    repeat (BT - 1) @(posedge sys_clk);
    #1;
    check("byte_to_hold", busy, 1'b1);
    @(posedge sys_clk);
    #1;
    check("byte_to_abort", busy, 1'b0);
    exp_err++;
    check("byte_to_err", err_cnt, exp_err);
    check("byte_to_no_req", req_rises, r0);

    // Transmitter held busy around both response bytes; a byte during TX is dropped.
    p0 = tx_pulses;
    force_busy = 1'b1;
    setup_frame(8'h57, 8'h44, 8'hC3, 2, 8'h00);
    send_byte(8'h57);
    send_byte(8'h44);
    sb.push_back(8'h4B);
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    repeat (20) @(posedge sys_clk);
    #1;
    check("hold1_no_tx", tx_pulses, p0);
    force_busy = 1'b0;
    for (int i = 0; i < 50 && tx_pulses == p0; i++) @(posedge sys_clk);
    #1;
    check("hold1_release", tx_pulses, p0 + 1);
    force_busy = 1'b1;
    send_byte(8'h52);
    exp_err++;
    check("tx_drop_err", err_cnt, exp_err);
    repeat (20) @(posedge sys_clk);
    #1;
    check("hold2_no_tx", tx_pulses, p0 + 1);
    force_busy = 1'b0;
    wait_idle("hold_idle", 200);
    check("hold_pulses", tx_pulses, p0 + 2);
    check("hold_sb_empty", sb.size(), 0);

    // Reset while the register request is outstanding.
    setup_frame(8'h57, 8'h66, 8'h99, -1, 8'h00);
    send_byte(8'h57);
    send_byte(8'h66);
    send_byte(8'h99);
    repeat (3) @(posedge sys_clk);
    #1;
    check("pre_rst_req", reg_req, 1'b1);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("mid_rst_req", reg_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err_cnt, 8'h00);
    rst = 1'b0;
    exp_err = 8'h00;
    setup_frame(8'h52, 8'h22, 8'h00, 1, 8'h3C);
    send_byte(8'h52);
    send_byte(8'h22);
    sb.push_back(8'h4B);
    sb.push_back(8'h3C);
    send_byte(8'h00);
    wait_idle("post_rst_idle", 200);
    check("post_rst_err", err_cnt, 8'h00);
    check("post_rst_sb", sb.size(), 0);

    // err_cnt saturation.
    for (int i = 0; i < 260; i++) send_byte(8'h00);
    check("err_saturate", err_cnt, 8'hFF);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
